// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX-stage branches against an always-taken fetch, redirecting and flushing on mispredict
module branch_resolve_unit #(
  parameter int Width       = 32,
  parameter int FlushCycles = 2,
  parameter int CntWidth    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [Width-1:0]    ex_pc_i,
  input  logic                stall_i,
  input  logic                BrLt,
  input  logic                BrEq,
  output logic                BrUn,
  output logic                taken_o,
  output logic                redirect_valid_o,
  output logic [Width-1:0]    redirect_pc_o,
  output logic                flush_o,
  output logic                illegal_o,
  output logic [CntWidth-1:0] branch_cnt_o,
  output logic [CntWidth-1:0] mispred_cnt_o
);
  localparam int FW = $clog2(FlushCycles + 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic flush_n, legal, eval, mispredict;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    flush_n = 1'b0;
    if (state == FLUSH) begin
      flush_n = 1'b1;
      if (!stall_i) begin
        state_n = fcnt == '0 ? IDLE : FLUSH;
        fcnt_n  = fcnt == '0 ? fcnt : fcnt - 1'b1;
        flush_n = fcnt != '0;
      end
    end else if (mispredict) begin
      flush_n = 1'b1;
      fcnt_n  = FW'(FlushCycles - 1);
      state_n = FlushCycles > 1 ? FLUSH : IDLE;
    end
  end
  // bit 0 of funct3 inverts the sense; bit 2 picks BrLt over BrEq
  always_comb begin
    BrUn       = ex_funct3_i[1];
    legal      = ex_funct3_i[2:1] != 2'b01;
    taken_o    = ex_valid_i & legal & (ex_funct3_i[2] ? ex_funct3_i[0] ^ BrLt : ex_funct3_i[0] ^ BrEq);
    eval       = ex_valid_i & !stall_i & (state == IDLE);
    mispredict = eval & !taken_o;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b0;
      illegal_o        <= 1'b0;
      branch_cnt_o     <= '0;
      mispred_cnt_o    <= '0;
    end else begin
      redirect_valid_o <= mispredict;
      illegal_o        <= mispredict & !legal;
      flush_o          <= flush_n;
      if (mispredict) redirect_pc_o <= ex_pc_i + Width'(4);
      if (eval & legal & (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (mispredict & legal & (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst, ex_valid_i, stall_i, BrLt, BrEq;
  logic [2:0] ex_funct3_i;
  logic [31:0] ex_pc_i;
  logic br_un, taken, rv, fl, il;
  logic [31:0] rpc, bc, mc;
  logic br_un4, taken4, rv4, fl4, il4;
  logic [31:0] rpc4;
  logic [3:0] bc4, mc4;
  int checks = 0, failures = 0;
  typedef struct {string tag; logic rv; logic [31:0] pc; logic il; logic fl;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_funct3_i(ex_funct3_i), .ex_pc_i(ex_pc_i),
    .stall_i(stall_i), .BrLt(BrLt), .BrEq(BrEq), .BrUn(br_un), .taken_o(taken),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .flush_o(fl), .illegal_o(il),
    .branch_cnt_o(bc), .mispred_cnt_o(mc));
  branch_resolve_unit #(.CntWidth(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_funct3_i(ex_funct3_i), .ex_pc_i(ex_pc_i),
    .stall_i(stall_i), .BrLt(BrLt), .BrEq(BrEq), .BrUn(br_un4), .taken_o(taken4),
    .redirect_valid_o(rv4), .redirect_pc_o(rpc4), .flush_o(fl4), .illegal_o(il4),
    .branch_cnt_o(bc4), .mispred_cnt_o(mc4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic r, input logic [31:0] pc, input logic i, input logic f);
    exp_t e;
    e.tag = tag; e.rv = r; e.pc = pc; e.il = i; e.fl = f;
    q.push_back(e);
  endtask
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected>=1");
    end else begin
      e = q.pop_front();
      chk1({e.tag, ".redirect_valid"}, rv, e.rv);
      chk({e.tag, ".redirect_pc"}, rpc, e.pc);
      chk1({e.tag, ".illegal"}, il, e.il);
      chk1({e.tag, ".flush"}, fl, e.fl);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] f3, input logic lt, input logic eq, input logic [31:0] pc);
    ex_valid_i = v; ex_funct3_i = f3; BrLt = lt; BrEq = eq; ex_pc_i = pc;
    #1;
  endtask
  initial begin
    rst = 1'b1; stall_i = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    push("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    pop_check();
    chk("reset.branch_cnt", bc, 32'd0);
    chk("reset.mispred_cnt", mc, 32'd0);
    // BEQ taken: speculation correct
    drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h100);
    chk1("beq.taken", taken, 1'b1);
    chk1("beq.brun", br_un, 1'b0);
    push("beq", 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0);
    pop_check();
    chk("beq.branch_cnt", bc, 32'd1);
    chk("beq.mispred_cnt", mc, 32'd0);
    // BNE not taken with a wrong-path branch during flush
    drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h200);
    chk1("bne.taken", taken, 1'b0);
    push("bne.c1", 1'b1, 32'h204, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h400);
    pop_check();
    chk("bne.branch_cnt", bc, 32'd2);
    chk("bne.mispred_cnt", mc, 32'd1);
    push("bne.c2", 1'b0, 32'h204, 1'b0, 1'b1);
    cyc();
    pop_check();
    push("bne.c3", 1'b0, 32'h204, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    pop_check();
    chk("wrongpath.branch_cnt", bc, 32'd2);
    chk("wrongpath.mispred_cnt", mc, 32'd1);
    // unsigned select and valid masking
    drive(1'b0, 3'b110, 1'b1, 1'b0, 32'h0);
    chk1("bltu.brun", br_un, 1'b1);
    chk1("masked.taken", taken, 1'b0);
    drive(1'b0, 3'b111, 1'b0, 1'b0, 32'h0);
    chk1("bgeu.brun", br_un, 1'b1);
    drive(1'b0, 3'b100, 1'b0, 1'b0, 32'h0);
    chk1("blt.brun", br_un, 1'b0);
    drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0);
    chk1("bge.brun", br_un, 1'b0);
    drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0);
    chk1("bge.taken", taken, 1'b1);
    drive(1'b1, 3'b110, 1'b1, 1'b0, 32'h0);
    chk1("bltu.taken", taken, 1'b1);
    drive(1'b1, 3'b111, 1'b1, 1'b0, 32'h500);
    chk1("bgeu.taken", taken, 1'b0);
    push("bgeu", 1'b1, 32'h504, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    pop_check();
    cyc(); cyc();
    chk1("bgeu.flush_end", fl, 1'b0);
    chk("bgeu.branch_cnt", bc, 32'd3);
    chk("bgeu.mispred_cnt", mc, 32'd2);
    // illegal funct3
    drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h300);
    chk1("illegal.taken", taken, 1'b0);
    push("illegal.c1", 1'b1, 32'h304, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    pop_check();
    push("illegal.c2", 1'b0, 32'h304, 1'b0, 1'b1);
    cyc();
    pop_check();
    chk("illegal.branch_cnt", bc, 32'd3);
    chk("illegal.mispred_cnt", mc, 32'd2);
    cyc();
    // stall inside FLUSH extends the flush
    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h600);
    push("stallflush.c1", 1'b1, 32'h604, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    stall_i = 1'b1;
    pop_check();
    for (int i = 0; i < 3; i++) begin
      push("stallflush.held", 1'b0, 32'h604, 1'b0, 1'b1);
      cyc();
      pop_check();
    end
    stall_i = 1'b0;
    push("stallflush.last", 1'b0, 32'h604, 1'b0, 1'b1);
    cyc();
    pop_check();
    push("stallflush.end", 1'b0, 32'h604, 1'b0, 1'b0);
    cyc();
    pop_check();
    chk("stallflush.mispred_cnt", mc, 32'd3);
    // stalled branch in IDLE counted once after release
    stall_i = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h700);
    cyc(); cyc();
    chk("stalled.branch_cnt", bc, 32'd4);
    chk1("stalled.redirect", rv, 1'b0);
    stall_i = 1'b0;
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("released.branch_cnt", bc, 32'd5);
    cyc();
    chk("released.branch_cnt_hold", bc, 32'd5);
    // redirect target wraps
    drive(1'b1, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFC);
    push("wrap", 1'b1, 32'h0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    pop_check();
    chk("wrap.mispred_cnt", mc, 32'd4);
    cyc(); cyc();
    // reset mid-flush
    drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h800);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    chk1("prereset.flush", fl, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push("midreset", 1'b0, 32'h0, 1'b0, 1'b0);
    pop_check();
    chk("midreset.branch_cnt", bc, 32'd0);
    chk("midreset.mispred_cnt", mc, 32'd0);
    drive(1'b0, 3'b110, 1'b0, 1'b0, 32'h0);
    chk1("midreset.brun", br_un, 1'b1);
    // narrow counter saturation
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h900);
      cyc();
      drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
      cyc(); cyc();
      if (i == 14) chk("sat.mispred_cnt_15", 32'(mc4), 32'hF);
    end
    chk("sat.mispred_cnt4", 32'(mc4), 32'hF);
    chk("sat.branch_cnt4", 32'(bc4), 32'hF);
    chk("sat.mispred_cnt32", mc, 32'd16);
    chk("sat.branch_cnt32", bc, 32'd16);
    chk("scoreboard.left", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the EX-stage branch comparator in the always-taken pipeline.
- Decodes the branch funct3 and drives the comparator's unsigned-select (BrUn). It turns the returned BrLt/BrEq flags into a taken/not-taken outcome.
- Fetch always speculates "taken". A not-taken outcome is a mispredict: the unit issues a registered PC redirect to pc+4 and a multi-cycle IF/ID flush.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- Width, 32, PC/data width
- FlushCycles, 2, cycles flush_o is held after a mispredict (≥1)
- CntWidth, 32, width of statistics counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- ex_valid_i  input  1  conditional branch present in EX
- ex_funct3_i  input  3  branch funct3
- ex_pc_i  input  Width  PC of branch in EX
- stall_i  input  1  pipeline stall; EX contents held
- BrLt  input  1  less-than flag from comparator
- BrEq  input  1  equal flag from comparator
- BrUn  output  1  unsigned-compare select to comparator
- taken_o  output  1  combinational resolved outcome
- redirect_valid_o  output  1  one-cycle redirect pulse to fetch
- redirect_pc_o  output  Width  redirect target
- flush_o  output  1  squash IF/ID
- illegal_o  output  1  one-cycle pulse: illegal funct3
- branch_cnt_o  output  CntWidth  resolved legal branches
- mispred_cnt_o  output  CntWidth  legal not-taken branches

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- BrUn = ex_funct3_i[1]. It is combinational and driven regardless of ex_valid_i.
- Decode of taken_o, masked by ex_valid_i, else 0:
  - 000 BEQ = BrEq
  - 001 BNE = !BrEq
  - 100 BLT and 110 BLTU = BrLt
  - 101 BGE and 111 BGEU = !BrLt
  - 010/011 illegal, taken_o = 0
- Evaluate event: ex_valid_i & !stall_i & state==IDLE. Fires at most once per held instruction, because EX is only re-presented after stall drops.
- FSM states: IDLE, FLUSH. Flush counter fcnt has width clog2(FlushCycles+1).
- IDLE, on evaluate event with a not-taken outcome (legal not-taken or illegal):
  - Next cycle: redirect_valid_o=1 for exactly one cycle.
  - redirect_pc_o = ex_pc_i+4, modulo 2^Width (0xFFFFFFFC → 0x00000000).
  - flush_o=1; fcnt=FlushCycles-1; state→FLUSH, or stays IDLE with one flush cycle if FlushCycles==1.
- IDLE, on evaluate event with taken: no redirect, no flush (speculation correct).
- FLUSH:
  - flush_o=1.
  - ex_valid_i is ignored (wrong-path instructions).
  - fcnt decrements each cycle with !stall_i and freezes while stall_i=1.
  - When fcnt==0 and !stall_i: state→IDLE, and flush_o=0 next cycle.
- Total flush_o high time = FlushCycles unstalled cycles.
- redirect_pc_o holds its last value when redirect_valid_o=0.
- illegal_o: registered one-cycle pulse, coincident with redirect_valid_o.
- Counters, updated on the evaluate edge:
  - branch_cnt_o +1 per legal branch.
  - mispred_cnt_o +1 per legal not-taken branch.
  - Illegal funct3 counts in neither.
  - Both saturate at all-ones; no wrap.
- Reset, including mid-FLUSH: state=IDLE, fcnt=0, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, illegal_o=0, counters=0. Combinational BrUn/taken_o follow inputs.
- Latency: outcome combinational in cycle N; redirect/flush/illegal/counters visible at cycle N+1.

Test Plan:
1. BEQ (000), BrEq=1, pc=0x100 → taken_o=1; no redirect/flush; branch_cnt=1, mispred_cnt=0.
2. BNE (001), BrEq=1, pc=0x200 → next cycle redirect_valid_o=1 for 1 cycle, redirect_pc_o=0x204; flush_o high exactly 2 cycles; mispred_cnt=1. A valid branch presented during flush is ignored, with counters unchanged.
3. BLTU/BGEU (110/111) → BrUn=1; BLT/BGE (100/101) → BrUn=0. BGEU with BrLt=1 → not taken, redirect.
4. funct3=010, pc=0x300 → illegal_o pulse plus redirect 0x304; branch_cnt and mispred_cnt unchanged.
5. Mispredict then stall_i=1 for 3 cycles inside FLUSH → flush_o stays high and extends by 3 cycles. A stalled branch in IDLE is counted once only after stall drops. pc=0xFFFFFFFC not-taken → redirect_pc_o=0x00000000.
6. Assert rst during FLUSH → next cycle flush_o=0, counters=0. With CntWidth=4, 16 mispredicts → mispred_cnt_o saturates at 0xF.
